// File: rtl/intersection_ctrl.sv
// intersection_ctrl
// Two-street intersection controller built around one timed phase machine.
// The main street rests on green; cross-street car and pedestrian calls are
// latched and served once the minimum main green has run, while an emergency
// request skips that minimum and holds the cross street green for as long as
// it stays asserted. Every duration is counted in prescaled ticks.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   car_sensor   cross-street car present (level)
//   ped_sensor   pedestrian button (pulse or level)
//   emer_signal  emergency pre-emption request (level, never latched)
//   R1/Y1/G1     main-street lamps
//   R2/Y2/G2     cross-street lamps
//   walk         pedestrian walk lamp
//   phase        current state code (0..5)
module intersection_ctrl #(
  parameter int TICK_DIV   = 1,
  parameter int CNT_W      = 8,
  parameter int T_MIN_MAIN = 8,
  parameter int T_YELLOW   = 3,
  parameter int T_ALL_RED  = 1,
  parameter int T_CROSS    = 6,
  parameter int T_PED      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_sensor,
  input  logic       ped_sensor,
  input  logic       emer_signal,
  output logic       R1,
  output logic       Y1,
  output logic       G1,
  output logic       R2,
  output logic       Y2,
  output logic       G2,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_GREEN   = 3'd0,
    MAIN_YELLOW  = 3'd1,
    ALL_RED_A    = 3'd2,
    CROSS_GREEN  = 3'd3,
    CROSS_YELLOW = 3'd4,
    ALL_RED_B    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TickLast  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DurMin    = CNT_W'(T_MIN_MAIN);
  localparam logic [CNT_W-1:0] DurYellow = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] DurAllRed = CNT_W'(T_ALL_RED);
  localparam logic [CNT_W-1:0] DurCross  = CNT_W'(T_CROSS);
  localparam logic [CNT_W-1:0] DurPed    = CNT_W'(T_PED);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] prescale_q, prescale_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             carReq_q, carReq_d;
  logic             pedReq_q, pedReq_d;
  logic             servePed_q, servePed_d;
  logic             tick;
  logic             stateChange;
  logic             enterCross;
  logic             anyCall;

  // A duration of D ticks is complete either once D ticks have already been
  // counted, or on the edge where the D-th tick lands. Checking the landing
  // tick lets the state leave on exactly the D*TICK_DIV-th edge after entry.
  function automatic logic phaseDone(input logic [CNT_W-1:0] t,
                                     input logic             tk,
                                     input logic [CNT_W-1:0] dur);
    if (tk) begin
      return t >= (dur - CNT_W'(1));
    end
    return t >= dur;
  endfunction

  assign tick    = (prescale_q == TickLast);
  assign anyCall = carReq_q | pedReq_q | car_sensor | ped_sensor;

  // Next-state logic. Emergency only matters in MAIN_GREEN (immediate exit)
  // and CROSS_GREEN (hold); the clearance states always run their full time.
  // Unused codes fall back to MAIN_GREEN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN: begin
        if (emer_signal || (phaseDone(timer_q, tick, DurMin) && anyCall)) begin
          state_d = MAIN_YELLOW;
        end
      end
      MAIN_YELLOW: begin
        if (phaseDone(timer_q, tick, DurYellow)) begin
          state_d = ALL_RED_A;
        end
      end
      ALL_RED_A: begin
        if (phaseDone(timer_q, tick, DurAllRed)) begin
          state_d = CROSS_GREEN;
        end
      end
      CROSS_GREEN: begin
        if (!emer_signal &&
            phaseDone(timer_q, tick, servePed_q ? DurPed : DurCross)) begin
          state_d = CROSS_YELLOW;
        end
      end
      CROSS_YELLOW: begin
        if (phaseDone(timer_q, tick, DurYellow)) begin
          state_d = ALL_RED_B;
        end
      end
      ALL_RED_B: begin
        if (phaseDone(timer_q, tick, DurAllRed)) begin
          state_d = MAIN_GREEN;
        end
      end
      default: state_d = MAIN_GREEN;
    endcase
  end

  // Timing and request bookkeeping. Prescaler and phase timer restart on
  // every state entry. Entering CROSS_GREEN consumes all pending calls,
  // including a sensor that is high on that very edge, and decides whether
  // this service is a pedestrian one.
  always_comb begin
    stateChange = (state_d != state_q);
    enterCross  = stateChange && (state_d == CROSS_GREEN);

    prescale_d = prescale_q + CNT_W'(1);
    if (stateChange || tick) begin
      prescale_d = '0;
    end

    timer_d = timer_q;
    if (stateChange) begin
      timer_d = '0;
    end else if (tick && (timer_q != '1)) begin
      timer_d = timer_q + CNT_W'(1);
    end

    carReq_d   = carReq_q | car_sensor;
    pedReq_d   = pedReq_q | ped_sensor;
    servePed_d = servePed_q;
    if (enterCross) begin
      carReq_d   = 1'b0;
      pedReq_d   = 1'b0;
      servePed_d = pedReq_q | ped_sensor;
    end
  end

  // State, timer and request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MAIN_GREEN;
      prescale_q <= '0;
      timer_q    <= '0;
      carReq_q   <= 1'b0;
      pedReq_q   <= 1'b0;
      servePed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      timer_q    <= timer_d;
      carReq_q   <= carReq_d;
      pedReq_q   <= pedReq_d;
      servePed_q <= servePed_d;
    end
  end

  // Lamp decode from the state register alone, so each head always shows
  // exactly one lamp. Walk is the one output that also looks at the live
  // emergency level so it drops the moment pre-emption starts.
  always_comb begin
    G1    = (state_q == MAIN_GREEN);
    Y1    = (state_q == MAIN_YELLOW);
    R1    = !(G1 || Y1);
    G2    = (state_q == CROSS_GREEN);
    Y2    = (state_q == CROSS_YELLOW);
    R2    = !(G2 || Y2);
    walk  = (state_q == CROSS_GREEN) && servePed_q && !emer_signal;
    phase = state_q;
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl
// Directed bench for intersection_ctrl. One instance uses the default
// parameters and is driven from per-edge vector tables; a second instance
// with TICK_DIV=4 shares the same inputs and is used for the prescaled
// duration checks.
module tb_intersection_ctrl;

  logic       clk;
  logic       reset;
  logic       carSensor;
  logic       pedSensor;
  logic       emerSignal;

  logic       r1, y1, g1, r2, y2, g2, walk;
  logic [2:0] phase;
  logic       r1b, y1b, g1b, r2b, y2b, g2b, walkB;
  logic [2:0] phaseB;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic       car;
    logic       ped;
    logic       emer;
    logic [2:0] expPhase;
    logic       expWalk;
  } vec_t;

  vec_t vecs[$];

  intersection_ctrl dut (
    .clk(clk), .reset(reset),
    .car_sensor(carSensor), .ped_sensor(pedSensor), .emer_signal(emerSignal),
    .R1(r1), .Y1(y1), .G1(g1), .R2(r2), .Y2(y2), .G2(g2),
    .walk(walk), .phase(phase)
  );

  intersection_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset),
    .car_sensor(carSensor), .ped_sensor(pedSensor), .emer_signal(emerSignal),
    .R1(r1b), .Y1(y1b), .G1(g1b), .R2(r2b), .Y2(y2b), .G2(g2b),
    .walk(walkB), .phase(phaseB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamps {R1,Y1,G1,R2,Y2,G2} for a phase code.
  function automatic logic [5:0] lampsFor(input logic [2:0] ph);
    logic m, c;
    m = (ph == 3'd0) || (ph == 3'd1);
    c = (ph == 3'd3) || (ph == 3'd4);
    return {!m, ph == 3'd1, ph == 3'd0, !c, ph == 3'd4, ph == 3'd3};
  endfunction

  // Drive the three sensor inputs.
  task automatic applyStimulus(input logic car, input logic ped, input logic emer);
    carSensor  = car;
    pedSensor  = ped;
    emerSignal = emer;
  endtask

  // Compare phase, both lamp heads and walk of the default instance.
  task automatic checkOutput(input string name, input logic [2:0] expPhase,
                             input logic expWalk);
    logic [5:0] gotLamps;
    logic [5:0] expLamps;
    gotLamps = {r1, y1, g1, r2, y2, g2};
    expLamps = lampsFor(expPhase);
    checks++;
    if (phase === expPhase) passes++;
    else $display("[TB] FAIL %s phase: got %0d expected %0d", name, phase, expPhase);
    checks++;
    if (gotLamps === expLamps) passes++;
    else $display("[TB] FAIL %s lamps: got %b expected %b", name, gotLamps, expLamps);
    checks++;
    if (walk === expWalk) passes++;
    else $display("[TB] FAIL %s walk: got %b expected %b", name, walk, expWalk);
  endtask

  // Compare a measured integer against its expected value.
  task automatic checkValue(input string name, input int got, input int expv);
    checks++;
    if (got == expv) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  // Reset both instances, check the reset state, release on a falling edge.
  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset", 3'd0, 1'b0);
    checkValue("reset tick4 phase", int'(phaseB), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Append n identical per-edge vectors to the table.
  task automatic addSeg(input int n, input logic car, input logic ped,
                        input logic emer, input logic [2:0] ph, input logic w);
    vec_t v;
    v.car = car; v.ped = ped; v.emer = emer; v.expPhase = ph; v.expWalk = w;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Apply every table entry before an edge and check just after that edge.
  task automatic runTable(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].car, vecs[i].ped, vecs[i].emer);
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s edge %0d", name, i + 1), vecs[i].expPhase, vecs[i].expWalk);
    end
    vecs.delete();
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Wait (bounded) for the default instance to reach a phase.
  task automatic waitForPhase(input logic [2:0] ph, input int limit, input string name);
    int n;
    n = 0;
    while (phase !== ph && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkValue(name, int'(phase), int'(ph));
  endtask

  // Count consecutive samples of the TICK_DIV=4 instance in phase ph,
  // starting from a sample already known to be in ph.
  task automatic countRun4(input logic [2:0] ph, output int n);
    n = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (phaseB == ph) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Idle: no calls for 200 cycles keeps main green.
    doReset();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("idle %0d", i), 3'd0, 1'b0);
    end

    // Car pulse at edge 3; a second car seen on the edge entering cross
    // green is consumed, so main green stays up afterwards.
    doReset();
    addSeg(2, 0, 0, 0, 3'd0, 0);
    addSeg(1, 1, 0, 0, 3'd0, 0);
    addSeg(4, 0, 0, 0, 3'd0, 0);
    addSeg(3, 0, 0, 0, 3'd1, 0);
    addSeg(1, 0, 0, 0, 3'd2, 0);
    addSeg(1, 1, 0, 0, 3'd3, 0);
    addSeg(5, 0, 0, 0, 3'd3, 0);
    addSeg(3, 0, 0, 0, 3'd4, 0);
    addSeg(1, 0, 0, 0, 3'd5, 0);
    addSeg(14, 0, 0, 0, 3'd0, 0);
    runTable("car");

    // Ped pulse: 10-cycle walk; a press during cross green triggers another
    // cycle after exactly the minimum main green.
    doReset();
    addSeg(2, 0, 0, 0, 3'd0, 0);
    addSeg(1, 0, 1, 0, 3'd0, 0);
    addSeg(4, 0, 0, 0, 3'd0, 0);
    addSeg(3, 0, 0, 0, 3'd1, 0);
    addSeg(1, 0, 0, 0, 3'd2, 0);
    addSeg(2, 0, 0, 0, 3'd3, 1);
    addSeg(1, 0, 1, 0, 3'd3, 1);
    addSeg(7, 0, 0, 0, 3'd3, 1);
    addSeg(3, 0, 0, 0, 3'd4, 0);
    addSeg(1, 0, 0, 0, 3'd5, 0);
    addSeg(8, 0, 0, 0, 3'd0, 0);
    addSeg(3, 0, 0, 0, 3'd1, 0);
    addSeg(1, 0, 0, 0, 3'd2, 0);
    addSeg(10, 0, 0, 0, 3'd3, 1);
    addSeg(1, 0, 0, 0, 3'd4, 0);
    runTable("ped");

    // Emergency from edge 3 for 30 edges, with a ped press during yellow:
    // minimum green skipped, cross green held, walk suppressed.
    doReset();
    addSeg(2, 0, 0, 0, 3'd0, 0);
    addSeg(1, 0, 0, 1, 3'd1, 0);
    addSeg(1, 0, 1, 1, 3'd1, 0);
    addSeg(1, 0, 0, 1, 3'd1, 0);
    addSeg(1, 0, 0, 1, 3'd2, 0);
    addSeg(26, 0, 0, 1, 3'd3, 0);
    addSeg(3, 0, 0, 0, 3'd4, 0);
    addSeg(1, 0, 0, 0, 3'd5, 0);
    addSeg(4, 0, 0, 0, 3'd0, 0);
    runTable("emer");

    // Prescaled durations on the TICK_DIV=4 instance.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    countRun4(3'd0, n);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("tick4 G1 cycles", n, 32);
    checkValue("tick4 phase after G1", int'(phaseB), 1);
    countRun4(3'd1, n);
    checkValue("tick4 Y1 cycles", n, 12);
    checkValue("tick4 phase after Y1", int'(phaseB), 2);
    countRun4(3'd2, n);
    checkValue("tick4 all-red cycles", n, 4);
    checkValue("tick4 phase after all-red", int'(phaseB), 3);
    countRun4(3'd3, n);
    checkValue("tick4 G2 cycles", n, 24);
    checkValue("tick4 phase after G2", int'(phaseB), 4);

    // Reset asserted mid cross green between edges takes effect at once;
    // afterwards the controller rests on main green.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitForPhase(3'd3, 40, "reach cross green");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async reset", 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("after reset %0d", i), 3'd0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
